// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: receiver state enum, data width, baud divisor helper
//
// Purpose : types and constants common to the UART receiver and a future transmitter.
// Contents: rx_state_t (IDLE, START, DATA, STOP, BREAK), DATA_BITS, calc_div().
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Rounded sys_clk cycles per oversample tick: round(clk / (baud * os)).
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator
//
// Purpose : divides the system clock down to OVERSAMPLE ticks per bit period.
// Ports   : i_clk  - system clock
//           i_rst  - asynchronous active-high reset (counter restarts at 0)
//           o_tick - single-cycle pulse when the counter reaches DIV-1
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
//
// Purpose : receives 8N1 frames on RsRx (16x oversampled, mid-bit sampling) and
//           presents each byte on a valid/ready interface; flags framing errors
//           and bytes dropped because the previous one was not yet accepted.
// Ports   : sys_clk   - system clock, all logic on rising edge
//           rst       - asynchronous active-high reset
//           RsRx      - serial input, idle high, asynchronous to sys_clk
//           rx_data   - received byte, stable while rx_valid is high
//           rx_valid  - byte available, held until rx_ready
//           rx_ready  - consumer accept
//           frame_err - one-cycle pulse: stop bit sampled low
//           overrun   - one-cycle pulse: byte completed while rx_valid held, byte dropped
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       RsRx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 w_tick;
  logic                 w_rxs;
  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_commit;

  uart_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .i_clk (sys_clk),
    .i_rst (rst),
    .o_tick(w_tick)
  );

  // Synchroniser resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RsRx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_commit  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_commit  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick && !w_rxs) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_cnt == HALF_M1) begin
              // Mid start bit: a line already high again was a glitch.
              r_cnt <= '0;
              if (w_rxs) begin
                r_state <= IDLE;
              end else begin
                r_state   <= DATA;
                r_bit_idx <= '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_cnt == FULL_M1) begin
              r_cnt   <= '0;
              // LSB arrives first; shifting in at the top leaves it at bit 0.
              r_shreg <= {w_rxs, r_shreg[DATA_BITS-1:1]};
              if (r_bit_idx == LAST_BIT) begin
                r_state <= STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_cnt == FULL_M1) begin
              r_cnt <= '0;
              if (w_rxs) begin
                r_commit <= 1'b1;
                r_state  <= IDLE;
              end else begin
                frame_err <= 1'b1;
                r_state   <= BREAK;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        BREAK: begin
          // A line held low must go high before another frame can start.
          if (w_tick && w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_shreg is not shifted again until well into the next frame, so it is
  // still the committed byte in the cycle after r_commit.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_commit) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= r_shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
